// File: rtl/motoro_uart_cmd_rx.sv
// UART 8N1 receiver and 5-byte command-frame decoder driving the 3-phase motor
// control registers (m3start, m3freq, m3invOrStop).
module motoro_uart_cmd_rx #(
  parameter int BAUD_DIV     = 434,
  parameter int FREQ_INIT    = 100,
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic       clk50mhz,
  input  logic       reset,
  input  logic       uRx,
  output logic       m3start,
  output logic [9:0] m3freq,
  output logic       m3invOrStop,
  output logic [7:0] rxByte,
  output logic       rxByteValid,
  output logic       frameOk,
  output logic       frameErr
);

  localparam int CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int TW   = $clog2(TIMEOUT_CLKS + 1);
  localparam int HALF = BAUD_DIV / 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} bitState_t;
  typedef enum logic [2:0] {HUNT, CMD, DH, DL, CHK} frameState_t;

  logic rxMeta, rxSync, rxPrev;
  logic rxFall;

  bitState_t   bitState;
  logic [CW-1:0] bitCnt;
  logic [2:0]  bitIdx;
  logic [7:0]  shiftReg;
  logic        stopErr;

  frameState_t frameState;
  logic [7:0]  cmdReg, dhReg, dlReg;
  logic [TW-1:0] tCnt;
  logic [9:0]  freqNew;

  always_ff @(posedge clk50mhz or posedge reset) begin
    if (reset) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= uRx;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
    end
  end

  assign rxFall = rxPrev & ~rxSync;

  always_ff @(posedge clk50mhz or posedge reset) begin
    if (reset) begin
      bitState    <= IDLE;
      bitCnt      <= '0;
      bitIdx      <= '0;
      shiftReg    <= '0;
      rxByte      <= '0;
      rxByteValid <= 1'b0;
      stopErr     <= 1'b0;
    end else begin
      rxByteValid <= 1'b0;
      stopErr     <= 1'b0;
      case (bitState)
        IDLE: begin
          bitCnt <= '0;
          bitIdx <= '0;
          if (rxFall) bitState <= START;
        end
        START: begin
          if (bitCnt == CW'(HALF - 1)) begin
            bitCnt   <= '0;
            bitState <= rxSync ? IDLE : DATA;
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
        DATA: begin
          if (bitCnt == CW'(BAUD_DIV - 1)) begin
            bitCnt   <= '0;
            shiftReg <= {rxSync, shiftReg[7:1]};
            if (bitIdx == 3'd7) bitState <= STOP;
            else                bitIdx   <= bitIdx + 1'b1;
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
        STOP: begin
          if (bitCnt == CW'(BAUD_DIV - 1)) begin
            bitCnt   <= '0;
            bitState <= IDLE;
            if (rxSync) begin
              rxByte      <= shiftReg;
              rxByteValid <= 1'b1;
            end else begin
              stopErr <= 1'b1;
            end
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
        default: bitState <= IDLE;
      endcase
    end
  end

  assign freqNew = {dhReg[1:0], dlReg};

  // A received byte takes priority over a same-cycle timeout; framing errors
  // are reported here (one cycle after the stop sample) so frameErr has one driver.
  always_ff @(posedge clk50mhz or posedge reset) begin
    if (reset) begin
      frameState  <= HUNT;
      cmdReg      <= '0;
      dhReg       <= '0;
      dlReg       <= '0;
      tCnt        <= '0;
      m3start     <= 1'b0;
      m3freq      <= 10'(FREQ_INIT);
      m3invOrStop <= 1'b0;
      frameOk     <= 1'b0;
      frameErr    <= 1'b0;
    end else begin
      frameOk  <= 1'b0;
      frameErr <= 1'b0;
      if (rxByteValid) begin
        tCnt <= '0;
        case (frameState)
          HUNT: if (rxByte == 8'hA5) frameState <= CMD;
          CMD: begin
            cmdReg     <= rxByte;
            frameState <= DH;
          end
          DH: begin
            dhReg      <= rxByte;
            frameState <= DL;
          end
          DL: begin
            dlReg      <= rxByte;
            frameState <= CHK;
          end
          CHK: begin
            frameState <= HUNT;
            if (rxByte != (cmdReg ^ dhReg ^ dlReg)) begin
              frameErr <= 1'b1;
            end else begin
              case (cmdReg)
                8'h01: begin
                  m3start <= dlReg[0];
                  frameOk <= 1'b1;
                end
                8'h02: begin
                  if (freqNew == 10'd0 || freqNew > 10'd1000) begin
                    frameErr <= 1'b1;
                  end else begin
                    m3freq  <= freqNew;
                    frameOk <= 1'b1;
                  end
                end
                8'h03: begin
                  m3invOrStop <= dlReg[0];
                  frameOk     <= 1'b1;
                end
                default: frameErr <= 1'b1;
              endcase
            end
          end
          default: frameState <= HUNT;
        endcase
      end else if (stopErr) begin
        frameState <= HUNT;
        tCnt       <= '0;
        frameErr   <= 1'b1;
      end else if (frameState != HUNT) begin
        if (tCnt == TW'(TIMEOUT_CLKS - 1)) begin
          frameState <= HUNT;
          tCnt       <= '0;
          frameErr   <= 1'b1;
        end else begin
          tCnt <= tCnt + 1'b1;
        end
      end else begin
        tCnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_motoro_uart_cmd_rx.sv
// Scoreboard bench for motoro_uart_cmd_rx: stimulus queues expected bytes and
// frame outcomes; a negedge monitor pops and compares on every DUT pulse.
module tb_motoro_uart_cmd_rx;

  localparam int BD = 16;
  localparam int TO = 500;

  logic       clk = 1'b0;
  logic       reset;
  logic       uRx;
  logic       m3start;
  logic [9:0] m3freq;
  logic       m3invOrStop;
  logic [7:0] rxByte;
  logic       rxByteValid;
  logic       frameOk;
  logic       frameErr;

  typedef struct packed {
    logic       ok;
    logic       st;
    logic [9:0] fr;
    logic       inv;
  } ev_t;

  ev_t        evQ[$];
  logic [7:0] byteQ[$];
  ev_t        mEv;
  int         passes = 0;
  int         total  = 0;

  motoro_uart_cmd_rx #(
    .BAUD_DIV(BD),
    .FREQ_INIT(100),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk50mhz(clk),
    .reset(reset),
    .uRx(uRx),
    .m3start(m3start),
    .m3freq(m3freq),
    .m3invOrStop(m3invOrStop),
    .rxByte(rxByte),
    .rxByteValid(rxByteValid),
    .frameOk(frameOk),
    .frameErr(frameErr)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rxByteValid) begin
      if (byteQ.size() == 0) begin
        total++;
        $display("FAIL unexpectedByte: got %0h, expected no rxByteValid", rxByte);
      end else begin
        check("rxByte", {24'd0, rxByte}, {24'd0, byteQ.pop_front()});
      end
    end
    if (frameOk && frameErr) begin
      total++;
      $display("FAIL okAndErr: got both pulses, expected at most one");
    end
    if (frameOk || frameErr) begin
      if (evQ.size() == 0) begin
        total++;
        $display("FAIL unexpectedFrame: got ok=%0d err=%0d, expected no event", frameOk, frameErr);
      end else begin
        mEv = evQ.pop_front();
        check("frameKind", {31'd0, frameOk}, {31'd0, mEv.ok});
        check("m3start", {31'd0, m3start}, {31'd0, mEv.st});
        check("m3freq", {22'd0, m3freq}, {22'd0, mEv.fr});
        check("m3invOrStop", {31'd0, m3invOrStop}, {31'd0, mEv.inv});
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    uRx = 1'b0;
    repeat (BD) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uRx = b[i];
      repeat (BD) @(posedge clk);
    end
    uRx = stopBit;
    repeat (BD) @(posedge clk);
    uRx = 1'b1;
    repeat (2 * BD) @(posedge clk);
  endtask

  task automatic sendGood(input logic [7:0] b);
    byteQ.push_back(b);
    sendByte(b, 1'b1);
  endtask

  task automatic sendFrame(input logic [7:0] b0, b1, b2, b3, b4);
    sendGood(b0);
    sendGood(b1);
    sendGood(b2);
    sendGood(b3);
    sendGood(b4);
  endtask

  task automatic pushEv(input logic ok, input logic st, input logic [9:0] fr, input logic inv);
    ev_t e;
    e.ok = ok; e.st = st; e.fr = fr; e.inv = inv;
    evQ.push_back(e);
  endtask

  task automatic checkResetState(input string tag);
    @(negedge clk);
    check({tag, ".m3start"}, {31'd0, m3start}, 32'd0);
    check({tag, ".m3freq"}, {22'd0, m3freq}, 32'd100);
    check({tag, ".m3invOrStop"}, {31'd0, m3invOrStop}, 32'd0);
    check({tag, ".rxByte"}, {24'd0, rxByte}, 32'd0);
    check({tag, ".pulses"}, {29'd0, rxByteValid, frameOk, frameErr}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    uRx   = 1'b1;
    repeat (5) @(posedge clk);
    checkResetState("reset");
    reset = 1'b0;
    repeat (10) @(posedge clk);

    // start command
    pushEv(1'b1, 1'b1, 10'd100, 1'b0);
    sendFrame(8'hA5, 8'h01, 8'h00, 8'h01, 8'h00);
    // frequency 500, then out-of-range 1001
    pushEv(1'b1, 1'b1, 10'd500, 1'b0);
    sendFrame(8'hA5, 8'h02, 8'h01, 8'hF4, 8'hF7);
    pushEv(1'b0, 1'b1, 10'd500, 1'b0);
    sendFrame(8'hA5, 8'h02, 8'h03, 8'hE9, 8'hE8);
    // bad checksum, then good reverse command
    pushEv(1'b0, 1'b1, 10'd500, 1'b0);
    sendFrame(8'hA5, 8'h03, 8'h00, 8'h01, 8'h00);
    pushEv(1'b1, 1'b1, 10'd500, 1'b1);
    sendFrame(8'hA5, 8'h03, 8'h00, 8'h01, 8'h02);

    // short glitch
    uRx = 1'b0;
    repeat (6) @(posedge clk);
    uRx = 1'b1;
    repeat (3 * BD) @(posedge clk);
    // stop bit held low
    pushEv(1'b0, 1'b1, 10'd500, 1'b1);
    sendByte(8'h5A, 1'b0);
    // leading junk before a valid stop command
    sendGood(8'h00);
    sendGood(8'hFF);
    pushEv(1'b1, 1'b0, 10'd500, 1'b1);
    sendFrame(8'hA5, 8'h01, 8'h00, 8'h00, 8'h01);

    // inter-byte timeout, then frequency 700
    sendGood(8'hA5);
    sendGood(8'h02);
    pushEv(1'b0, 1'b0, 10'd500, 1'b1);
    repeat (TO + 100) @(posedge clk);
    check("timeoutSeen", evQ.size(), 32'd0);
    pushEv(1'b1, 1'b0, 10'd700, 1'b1);
    sendFrame(8'hA5, 8'h02, 8'h02, 8'hBC, 8'hBC);

    // reset partway through the DL byte
    sendGood(8'hA5);
    sendGood(8'h02);
    sendGood(8'h01);
    uRx = 1'b0;
    repeat (BD) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      uRx = ~i[0];
      repeat (BD) @(posedge clk);
    end
    reset = 1'b1;
    uRx   = 1'b1;
    repeat (3) @(posedge clk);
    checkResetState("midReset");
    check("byteQ.midReset", byteQ.size(), 32'd0);
    check("evQ.midReset", evQ.size(), 32'd0);
    reset = 1'b0;
    repeat (4 * BD) @(posedge clk);
    pushEv(1'b1, 1'b0, 10'd300, 1'b0);
    sendFrame(8'hA5, 8'h02, 8'h01, 8'h2C, 8'h2F);

    repeat (50) @(posedge clk);
    check("byteQ.end", byteQ.size(), 32'd0);
    check("evQ.end", evQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/motoro_uart_cmd_rx.md
Name: motoro_uart_cmd_rx

Overview:
- UART receiver and command-frame decoder for the 3-phase motor controller. It is the receive-side counterpart of the existing uTx debug transmitter.
- Takes a serial line from the host, checks fixed 5-byte command frames, and drives the motor control registers m3start, m3freq and m3invOrStop. In the top level these outputs replace the direct pins.
- Single clock domain, clk50mhz.

Parameters:
- BAUD_DIV, 434, clk50mhz cycles per bit (50 MHz / 115200). The bench uses 16.
- FREQ_INIT, 100, reset value of m3freq.
- TIMEOUT_CLKS, 50000, maximum idle clocks between bytes inside a frame (1 ms).

Ports:
- clk50mhz  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- uRx  in  1  serial input, idle high, 8N1, LSB first
- m3start  out  1  motor run enable
- m3freq  out  10  motor frequency setpoint
- m3invOrStop  out  1  reverse/stop request
- rxByte  out  8  last received byte
- rxByteValid  out  1  one-cycle pulse when rxByte updates
- frameOk  out  1  one-cycle pulse when a frame is accepted
- frameErr  out  1  one-cycle pulse when a frame or byte is rejected

Behaviour:
- Reset values: m3start=0, m3freq=FREQ_INIT, m3invOrStop=0, rxByte=0, all pulses=0. Both state machines go to IDLE / HUNT.
- Input sync: uRx passes through a 2-flop synchronizer; reset value of both flops is 1. All logic below uses the synchronized signal.
- Bit FSM states: IDLE, START, DATA, STOP.
- IDLE -> START on a synchronized falling edge.
- START: wait BAUD_DIV/2 clocks (integer division), then sample. If high, it is a glitch: return to IDLE with no pulse. If low, go to DATA.
- DATA: sample 8 bits, each BAUD_DIV clocks after the previous sample, shifting LSB first.
- STOP: sample BAUD_DIV clocks after bit 7.
  - Sample high: rxByte <= shifted byte and rxByteValid pulses on the next cycle.
  - Sample low (framing error): frameErr pulses, the byte is discarded, and the parser returns to HUNT.
  - In both cases the FSM returns to IDLE immediately after the stop sample, so back-to-back bytes are accepted.
- Frame format: 0xA5, CMD, DH, DL, CHK, where CHK = CMD ^ DH ^ DL.
- Frame FSM states: HUNT, CMD, DH, DL, CHK. It advances once per rxByteValid.
  - HUNT ignores every byte except 0xA5. Ignored bytes produce no error.
- Checks on the CHK byte:
  - CHK mismatch -> frameErr.
  - Unknown CMD -> frameErr.
  - Either way, no register changes and the FSM returns to HUNT.
- Commands. Register updates occur in the same cycle frameOk pulses, one clock after the CHK byte's rxByteValid.
  - 0x01: m3start <= DL[0].
  - 0x02: m3freq <= {DH[1:0], DL}. A value of 0 or greater than 1000 is rejected with frameErr and m3freq is held.
  - 0x03: m3invOrStop <= DL[0].
  - Unused DH/DL bits are ignored.
- Timeout: a counter clears on each rxByteValid and counts while the frame FSM is not in HUNT. Reaching TIMEOUT_CLKS -> frameErr pulse and return to HUNT.
- Simultaneous events: a timeout and an rxByteValid in the same cycle are resolved in favour of the byte (the counter clears and the FSM advances).
- frameOk and frameErr are never asserted together.
- Reset mid-byte or mid-frame aborts immediately. Outputs return to reset values with no pulse.

Test Plan (BAUD_DIV=16, FREQ_INIT=100):
- Valid start frame A5 01 00 01 00 -> one frameOk pulse; m3start 0->1; m3freq stays 100; frameErr never asserted.
- Frequency frame A5 02 01 F4 F7 -> m3freq=500. Then A5 02 03 E9 E8 (value 1001) -> frameErr; m3freq stays 500.
- Checksum error A5 03 00 01 00 -> frameErr; m3invOrStop stays 0. A following correct A5 03 00 01 02 -> m3invOrStop=1 and frameOk.
- Line noise: 6-clock low glitch on uRx -> no rxByteValid. Byte 0x5A with stop bit forced low -> frameErr, no rxByteValid. Leading junk 00 FF before a valid frame -> frame still accepted.
- Timeout: send A5 02, idle TIMEOUT_CLKS clocks -> frameErr. Then a full valid frame -> accepted.
- Assert reset during the DL byte of a frequency frame -> m3freq=100, FSMs idle. The next valid frame decodes correctly.
